// File: rtl/clock_core.sv
// Time-of-day core: 1 Hz prescaler, BCD sec/min/hour chain with 12/24-hour mode,
// button-driven set mode and a per-digit blink mask for the field being edited.
module clock_core #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter bit          MODE24    = 1'b1,
    parameter int unsigned BLINK_DIV = CLK_HZ / 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       sel,
    input  logic       up,
    input  logic       clr,
    output logic [3:0] sec_l,
    output logic [3:0] sec_u,
    output logic [3:0] min_l,
    output logic [3:0] min_u,
    output logic [3:0] hour_l,
    output logic [3:0] hour_u,
    output logic       pm,
    output logic [5:0] blank,
    output logic [1:0] mode,
    output logic       tick,
    output logic       day_wrap
);

    localparam int unsigned PW = $clog2(CLK_HZ);
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] SET_H = 2'd1;
    localparam logic [1:0] SET_M = 2'd2;
    localparam logic [1:0] SET_S = 2'd3;

    localparam logic [3:0] HOUR_U_RST = MODE24 ? 4'd0 : 4'd1;
    localparam logic [3:0] HOUR_L_RST = MODE24 ? 4'd0 : 4'd2;

    logic [PW-1:0] pre, pre_n;
    logic [BW-1:0] bcnt, bcnt_n;
    logic          phase, phase_n;
    logic [1:0]    mode_n;
    logic [7:0]    sec_n, min_n, hour_n;
    logic          pm_n, day_wrap_n;
    logic [5:0]    blank_n;
    logic          advance;
    logic          sec_top, min_top, hour_top;

    // BCD 00..59 increment, wrapping to 00
    function automatic logic [7:0] inc59(input logic [3:0] u, input logic [3:0] l);
        logic [7:0] r;
        if (l == 4'd9) r = (u == 4'd5) ? 8'h00 : {u + 4'd1, 4'd0};
        else           r = {u, l + 4'd1};
        return r;
    endfunction

    // Next hour as {pm, hour_u, hour_l}; 12-hour order is 12,01..11 with pm toggling at 11->12
    function automatic logic [8:0] inc_hour(input logic [3:0] u, input logic [3:0] l,
                                            input logic p);
        logic [8:0] r;
        if (MODE24) begin
            if (u == 4'd2 && l == 4'd3) r = {1'b0, 8'h00};
            else if (l == 4'd9)         r = {1'b0, u + 4'd1, 4'd0};
            else                        r = {1'b0, u, l + 4'd1};
        end else begin
            if (u == 4'd1 && l == 4'd1)      r = {~p, 4'd1, 4'd2};
            else if (u == 4'd1 && l == 4'd2) r = {p, 4'd0, 4'd1};
            else if (l == 4'd9)              r = {p, 4'd1, 4'd0};
            else                             r = {p, u, l + 4'd1};
        end
        return r;
    endfunction

    assign tick     = (mode == RUN) && (pre == PRE_MAX);
    assign sec_top  = (sec_u == 4'd5) && (sec_l == 4'd9);
    assign min_top  = (min_u == 4'd5) && (min_l == 4'd9);
    assign hour_top = MODE24 ? (hour_u == 4'd2 && hour_l == 4'd3)
                             : (hour_u == 4'd1 && hour_l == 4'd1 && pm);

    // Mode sequencing, time update, prescaler and blink next-state
    always_comb begin
        mode_n     = mode;
        pre_n      = pre;
        bcnt_n     = bcnt;
        phase_n    = phase;
        sec_n      = {sec_u, sec_l};
        min_n      = {min_u, min_l};
        hour_n     = {hour_u, hour_l};
        pm_n       = pm;
        day_wrap_n = 1'b0;
        blank_n    = 6'd0;
        advance    = 1'b0;

        if (mode == RUN) begin
            if (sel) begin
                mode_n  = SET_H;
                pre_n   = '0;
                advance = tick;
            end else if (clr) begin
                sec_n = 8'h00;
                pre_n = '0;
            end else begin
                pre_n   = tick ? '0 : pre + PW'(1);
                advance = tick;
            end
        end else begin
            pre_n = '0;
            if (sel) begin
                mode_n = mode + 2'd1;  // SET_S wraps back to RUN
            end else if (clr) begin
                case (mode)
                    SET_H: begin
                        hour_n = {HOUR_U_RST, HOUR_L_RST};
                        pm_n   = 1'b0;
                    end
                    SET_M:   min_n = 8'h00;
                    default: sec_n = 8'h00;
                endcase
            end else if (up) begin
                case (mode)
                    SET_H:   {pm_n, hour_n} = inc_hour(hour_u, hour_l, pm);
                    SET_M:   min_n = inc59(min_u, min_l);
                    default: sec_n = inc59(sec_u, sec_l);
                endcase
            end
        end

        // Full carry ripple within one edge
        if (advance) begin
            sec_n = inc59(sec_u, sec_l);
            if (sec_top) begin
                min_n = inc59(min_u, min_l);
                if (min_top) begin
                    {pm_n, hour_n} = inc_hour(hour_u, hour_l, pm);
                    day_wrap_n     = hour_top;
                end
            end
        end

        if (mode_n == RUN || sel || clr || up) begin
            bcnt_n  = '0;
            phase_n = 1'b0;
        end else if (bcnt == BLK_MAX) begin
            bcnt_n  = '0;
            phase_n = ~phase;
        end else begin
            bcnt_n = bcnt + BW'(1);
        end

        if (phase_n) begin
            case (mode_n)
                SET_H:   blank_n = 6'b110000;
                SET_M:   blank_n = 6'b001100;
                SET_S:   blank_n = 6'b000011;
                default: blank_n = 6'b000000;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mode     <= RUN;
            pre      <= '0;
            bcnt     <= '0;
            phase    <= 1'b0;
            sec_u    <= 4'd0;
            sec_l    <= 4'd0;
            min_u    <= 4'd0;
            min_l    <= 4'd0;
            hour_u   <= HOUR_U_RST;
            hour_l   <= HOUR_L_RST;
            pm       <= 1'b0;
            blank    <= 6'd0;
            day_wrap <= 1'b0;
        end else begin
            mode             <= mode_n;
            pre              <= pre_n;
            bcnt             <= bcnt_n;
            phase            <= phase_n;
            {sec_u, sec_l}   <= sec_n;
            {min_u, min_l}   <= min_n;
            {hour_u, hour_l} <= hour_n;
            pm               <= MODE24 ? 1'b0 : pm_n;
            blank            <= blank_n;
            day_wrap         <= day_wrap_n;
        end
    end

endmodule

// File: doc/clock_core.md
# clock_core

Parametrised time-of-day core for the seven-segment clock. It replaces the fixed 1 Hz counter and the sec/min/hour counter chain with a single block that adds 12/24-hour mode, an interactive set mode for hours, minutes and seconds, and a digit-blank mask for blinking the field being edited. It sits between the button debouncer (single-cycle pulses in) and the per-digit 7-seg decoders (BCD digits out).

## Interface
- CLK_HZ, 50_000_000: CLK cycles per second; must be ≥ 2.
- MODE24, 1: 1 selects 24-hour mode (00–23); 0 selects 12-hour mode (12,01–11 plus pm flag).
- BLINK_DIV, CLK_HZ/4: CLK cycles per blink half-period; must be ≥ 1.
- CLK  in  1  system clock; all state changes on its rising edge.
- RST  in  1  asynchronous active-low reset.
- sel  in  1  debounced one-cycle pulse; advances mode.
- up  in  1  debounced one-cycle pulse; increments the selected field in set states.
- clr  in  1  debounced one-cycle pulse; clears seconds (RUN) or the selected field (set states).
- sec_l, sec_u, min_l, min_u, hour_l, hour_u  out  4 each  BCD digits.
- pm  out  1  PM flag; held 0 when MODE24=1.
- blank  out  6  per-digit blank, bit0=sec_l … bit5=hour_u; 1 = digit off.
- mode  out  2  0=RUN, 1=SET_H, 2=SET_M, 3=SET_S.
- tick  out  1  one-cycle 1 Hz strobe.
- day_wrap  out  1  one-cycle pulse on the day rollover.

## Operation
- **Reset values:**
  - All digits 0, except hour_u=1 and hour_l=2 when MODE24=0.
  - pm=0, blank=0, mode=RUN, tick=0, day_wrap=0.
  - Prescaler 0, blink phase 0.
- **Prescaler:**
  - Counts 0..CLK_HZ-1 in RUN only.
  - tick=1 combinationally while count==CLK_HZ-1.
  - In set states it is held at 0 and tick=0.
- **RUN, on a tick:**
  - Seconds increment.
  - 59→00 carries into minutes; minutes 59→00 carries into hours.
  - 24-hour hours: 23→00 with carry sets day_wrap.
  - 12-hour hours: 11→12 toggles pm; 12→01; 11 PM→12 AM sets day_wrap.
  - All carries take effect in the same cycle (BCD ripple inside one edge).
- **Mode state machine:** a sel pulse steps RUN→SET_H→SET_M→SET_S→RUN.
  - Entering SET_H zeroes the prescaler.
  - Leaving SET_S zeroes the prescaler, so the first tick comes CLK_HZ cycles after the return to RUN.
- **up in a set state:** increments the selected field with wrap and no carry into other fields.
  - sec/min wrap 59→00.
  - 24-hour hours wrap 23→00.
  - 12-hour hours follow the same sequence as RUN, including the pm toggle at 11→12, so 24 pulses return to the start.
  - up in RUN is ignored.
- **clr:**
  - In RUN: seconds←00 and prescaler←0. Minutes and hours are unchanged.
  - In SET_H: hours←00, or 12 with pm←0 when MODE24=0.
  - In SET_M / SET_S: the selected field←00.
- **Priority when pulses coincide:**
  - sel > clr > up; lower-priority pulses that cycle are dropped.
  - In RUN, clr coinciding with a tick: clr wins and the tick increment is dropped.
- **Blink:**
  - In set states a phase counter toggles the phase every BLINK_DIV cycles.
  - While phase=1, the two blank bits of the selected field are 1; all other bits are 0.
  - Entering a set state, or any up/clr pulse, resets counter and phase to 0, so the field is visible.
  - In RUN, blank=0.

## Timing
- All outputs are registered except tick, which is decoded from the prescaler.
- Digit update latency: digits show the new value on the edge that samples tick=1 or up/clr=1, visible the next cycle.
- day_wrap is a registered one-cycle pulse, high in the same cycle the 00:00:00 (or 12:00:00 AM) value first appears.
- mode changes one edge after sel.
- Asserting RST mid-operation, including mid-set or mid-carry, forces reset values immediately.
- After RST deassertion the first tick occurs at cycle CLK_HZ-1.
- Digits never present a non-BCD or out-of-range value, including on the carry cycle.

## Test plan
- CLK_HZ=10, MODE24=1, reset, run 600 cycles → exactly 60 tick pulses; time 00:01:00; day_wrap never high.
- MODE24=1, preset 23:59:59 via set mode, return to RUN, one tick → 00:00:00 with day_wrap high for exactly one cycle.
- MODE24=0 from reset (12:00:00 AM), step hours via SET_H with 12 up pulses → 12 PM shown with pm=1 after the 12th; 12 more pulses → 12 AM, pm=0.
- SET_M with minutes=59, one up → minutes=00, hours unchanged; blank bits [3:2] show phase 0 for BLINK_DIV cycles, then 1; bits [5:4] and [1:0] stay 0.
- RUN at 00:00:37, clr and tick in the same cycle → 00:00:00, next tick CLK_HZ cycles later; sel+up in the same cycle in SET_S → mode=RUN, seconds unchanged.
- RST pulled low in SET_M mid-blink → mode=RUN, blank=0, digits at reset values that same cycle; after release, first tick at cycle CLK_HZ-1.
